// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack bus for loads and stores,
// stalls upstream through memReady while an access is outstanding, and
// registers the selected write-back value into the MEM/WB outputs.
module mem_access_stage #(
  parameter int          ADDR_W   = 10,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  // EXE/MEM register contents
  input  logic              valid_in,
  input  logic              DataMemWE,
  input  logic              WriteDataSrc,
  input  logic [31:0]       ALURes,
  input  logic [31:0]       Reg2DataOut,
  input  logic              WriteRegSrc,
  // upstream stall
  output logic              memReady,
  // data-memory bus
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  // MEM/WB register
  output logic [31:0]       WriteData_out,
  output logic              WriteRegSrc_out,
  output logic              valid_out,
  output logic              mem_err
);

  // Counter is one bit wider than needed so TIMEOUT itself is representable.
  localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       stateReg;
  logic [CNT_W-1:0] counterReg;
  logic [31:0]      rdataQ;

  logic access;
  logic misal;
  logic startAccess;

  assign access      = valid_in & (DataMemWE | WriteDataSrc);
  assign misal       = access & (ALURes[1:0] != 2'b00);
  assign startAccess = access & ~misal;

  // Upstream may advance when idle with nothing to fetch/store, or for the
  // single cycle in which a finished access is handed to MEM/WB.
  assign memReady = ((stateReg == IDLE) & ~startAccess) | (stateReg == DONE);

  // Access FSM and registered bus outputs; mem_ack is only ever sampled here,
  // so there is no combinational path from ack back to req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      counterReg <= '0;
      rdataQ     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_err    <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (startAccess) begin
            mem_req    <= 1'b1;
            mem_we     <= DataMemWE;
            mem_addr   <= ALURes[ADDR_W+1:2];
            mem_wdata  <= Reg2DataOut;
            counterReg <= '0;
            stateReg   <= BUSY;
          end else if (misal) begin
            mem_err <= 1'b1;
          end
        end
        BUSY: begin
          counterReg <= counterReg + CNT_W'(1);
          // An ack arriving on the timeout cycle still completes normally.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            rdataQ   <= mem_rdata;
            stateReg <= DONE;
          end else if (counterReg == LAST_CNT) begin
            mem_req  <= 1'b0;
            rdataQ   <= ERR_DATA;
            mem_err  <= 1'b1;
            stateReg <= DONE;
          end
        end
        DONE: begin
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: load the instruction when upstream advances, otherwise
  // insert a bubble while keeping the last write-back value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteData_out   <= '0;
      WriteRegSrc_out <= 1'b0;
      valid_out       <= 1'b0;
    end else if (memReady) begin
      valid_out       <= valid_in;
      WriteRegSrc_out <= misal ? 1'b0 : (WriteRegSrc & valid_in);
      WriteData_out   <= WriteDataSrc ? rdataQ : ALURes;
    end else begin
      valid_out       <= 1'b0;
      WriteRegSrc_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: ALU pass-through, load, store,
// timeout, ack-on-timeout, misaligned access and asynchronous reset mid-access.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        DataMemWE;
  logic        WriteDataSrc;
  logic [31:0] ALURes;
  logic [31:0] Reg2DataOut;
  logic        WriteRegSrc;
  logic        memReady;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] WriteData_out;
  logic        WriteRegSrc_out;
  logic        valid_out;
  logic        mem_err;

  int nChecks = 0;
  int nErrors = 0;
  int reqCycles;
  int errPulses;

  mem_access_stage #(
    .ADDR_W  (10),
    .TIMEOUT (16),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .DataMemWE      (DataMemWE),
    .WriteDataSrc   (WriteDataSrc),
    .ALURes         (ALURes),
    .Reg2DataOut    (Reg2DataOut),
    .WriteRegSrc    (WriteRegSrc),
    .memReady       (memReady),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .WriteData_out  (WriteData_out),
    .WriteRegSrc_out(WriteRegSrc_out),
    .valid_out      (valid_out),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v, input logic we, input logic wds,
                       input logic [31:0] alu, input logic [31:0] r2, input logic wrs);
    valid_in     = v;
    DataMemWE    = we;
    WriteDataSrc = wds;
    ALURes       = alu;
    Reg2DataOut  = r2;
    WriteRegSrc  = wrs;
  endtask

  task automatic setIdle();
    setIn(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // hard stop if something hangs
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    setIdle();
    #2;
    checkVal("rst_mem_req",   32'(mem_req), 32'd0);
    checkVal("rst_mem_we",    32'(mem_we), 32'd0);
    checkVal("rst_mem_addr",  32'(mem_addr), 32'd0);
    checkVal("rst_wdata_out", WriteData_out, 32'd0);
    checkVal("rst_valid_out", 32'(valid_out), 32'd0);
    checkVal("rst_mem_err",   32'(mem_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1: ALU op, no stall
    setIn(1'b1, 1'b0, 1'b0, 32'h15, 32'h0, 1'b1);
    #1;
    checkVal("alu_ready", 32'(memReady), 32'd1);
    step();
    checkVal("alu_wdata", WriteData_out, 32'h15);
    checkVal("alu_wrs",   32'(WriteRegSrc_out), 32'd1);
    checkVal("alu_valid", 32'(valid_out), 32'd1);
    checkVal("alu_noreq", 32'(mem_req), 32'd0);

    // 2: aligned load, ack in first BUSY cycle
    setIn(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
    #1;
    checkVal("ld_idle_stall", 32'(memReady), 32'd0);
    step();
    checkVal("ld_req",   32'(mem_req), 32'd1);
    checkVal("ld_addr",  32'(mem_addr), 32'h010);
    checkVal("ld_we",    32'(mem_we), 32'd0);
    checkVal("ld_bubble", 32'(valid_out), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE0001;
    #1;
    checkVal("ld_busy_stall", 32'(memReady), 32'd0);
    step();
    mem_ack = 1'b0;
    checkVal("ld_req_drop", 32'(mem_req), 32'd0);
    checkVal("ld_done_ready", 32'(memReady), 32'd1);
    step();
    checkVal("ld_wdata", WriteData_out, 32'hCAFE0001);
    checkVal("ld_valid", 32'(valid_out), 32'd1);
    checkVal("ld_wrs",   32'(WriteRegSrc_out), 32'd1);
    setIdle();

    // 3: store, ack in 4th BUSY cycle, bus stable throughout
    setIn(1'b1, 1'b1, 1'b0, 32'h8, 32'hA5A5A5A5, 1'b0);
    step();
    checkVal("st_addr", 32'(mem_addr), 32'h002);
    for (int i = 0; i < 3; i++) begin
      checkVal("st_req",   32'(mem_req), 32'd1);
      checkVal("st_we",    32'(mem_we), 32'd1);
      checkVal("st_wdata", mem_wdata, 32'hA5A5A5A5);
      checkVal("st_stall", 32'(memReady), 32'd0);
      step();
    end
    checkVal("st_req4", 32'(mem_req), 32'd1);
    checkVal("st_we4",  32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkVal("st_req_drop",   32'(mem_req), 32'd0);
    checkVal("st_done_ready", 32'(memReady), 32'd1);
    checkVal("st_noerr",      32'(mem_err), 32'd0);
    step();
    checkVal("st_valid",      32'(valid_out), 32'd1);
    checkVal("st_wrs",        32'(WriteRegSrc_out), 32'd0);
    // still presenting the store: back in IDLE means stall again, not a second DONE
    checkVal("st_one_done",   32'(memReady), 32'd0);
    setIdle();
    #1;

    // 4: load with no ack -> timeout after 16 BUSY cycles
    setIn(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 1'b1);
    step();
    reqCycles = 0;
    errPulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      reqCycles++;
      step();
      if (mem_err) errPulses++;
    end
    checkVal("to_req_cycles", 32'(reqCycles), 32'd16);
    checkVal("to_err_pulses", 32'(errPulses), 32'd1);
    checkVal("to_done_ready", 32'(memReady), 32'd1);
    step();
    checkVal("to_wdata",    WriteData_out, 32'hDEADBEEF);
    checkVal("to_valid",    32'(valid_out), 32'd1);
    checkVal("to_err_once", 32'(mem_err), 32'd0);
    setIdle();

    // 4b: ack on the timeout cycle wins, no error
    setIn(1'b1, 1'b0, 1'b1, 32'hC0, 32'h0, 1'b1);
    step();
    repeat (15) step();
    checkVal("tw_req_still", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    step();
    mem_ack = 1'b0;
    checkVal("tw_noerr",   32'(mem_err), 32'd0);
    checkVal("tw_req_drop", 32'(mem_req), 32'd0);
    checkVal("tw_ready",   32'(memReady), 32'd1);
    step();
    checkVal("tw_wdata", WriteData_out, 32'h0BADF00D);
    setIdle();

    // 5: misaligned load
    setIn(1'b1, 1'b0, 1'b1, 32'h42, 32'h0, 1'b1);
    #1;
    checkVal("mis_ready", 32'(memReady), 32'd1);
    step();
    checkVal("mis_noreq", 32'(mem_req), 32'd0);
    checkVal("mis_err",   32'(mem_err), 32'd1);
    checkVal("mis_wrs",   32'(WriteRegSrc_out), 32'd0);
    setIdle();
    step();
    checkVal("mis_err_pulse", 32'(mem_err), 32'd0);

    // ack while IDLE is ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    checkVal("stray_ack_req",   32'(mem_req), 32'd0);
    checkVal("stray_ack_ready", 32'(memReady), 32'd1);

    // 6: async reset mid-BUSY
    setIn(1'b1, 1'b1, 1'b0, 32'h100, 32'h12345678, 1'b1);
    step();
    checkVal("rb_req", 32'(mem_req), 32'd1);
    step();
    #3;
    rst = 1'b1;
    #1;
    checkVal("rb_req_drop", 32'(mem_req), 32'd0);
    checkVal("rb_we",       32'(mem_we), 32'd0);
    checkVal("rb_addr",     32'(mem_addr), 32'd0);
    checkVal("rb_wdata",    mem_wdata, 32'd0);
    checkVal("rb_wd_out",   WriteData_out, 32'd0);
    checkVal("rb_valid",    32'(valid_out), 32'd0);
    setIdle();
    @(negedge clk);
    rst = 1'b0;
    step();
    // a fresh aligned load must stall in IDLE and then issue
    setIn(1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 1'b1);
    #1;
    checkVal("rb_idle_stall", 32'(memReady), 32'd0);
    step();
    checkVal("rb_req2",  32'(mem_req), 32'd1);
    checkVal("rb_addr2", 32'(mem_addr), 32'h041);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    step();
    checkVal("rb_ld_wdata", WriteData_out, 32'h12345678);
    checkVal("rb_ld_valid", 32'(valid_out), 32'd1);
    setIdle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
